// File: rtl/quad_emu_pkg.sv
// Shared definitions for the quadrature encoder emulator.
//   scale_t  : per-delta sensitivity selector shared by all axes
//   sat_lim  : symmetric accumulator clamp magnitude for a given width
package quad_emu_pkg;

  typedef enum logic [1:0] {
    SCALE_QTR  = 2'd0,  // |d| >> 2
    SCALE_HALF = 2'd1,  // |d| >> 1
    SCALE_ONE  = 2'd2,  // |d|
    SCALE_DBL  = 2'd3   // |d| << 1
  } scale_t;

  // Largest magnitude an ACC_W-bit accumulator may hold. The negative
  // extreme is left unused so clamping is symmetric.
  function automatic int sat_lim(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/quad_axis_channel.sv
// One emulated quadrature axis: scales incoming deltas, accumulates them
// with symmetric saturation and drains the accumulator one step at a time
// at most once every step_period+1 cycles.
//
// Ports
//   clk, reset     core clock, synchronous active-high reset
//   clear          holds acc/timer/flags cleared and ignores deltas;
//                  the phase is kept so releasing it causes no step burst
//   delta_valid    one-cycle strobe; there is no ready, a strobed delta is
//                  always accepted on the edge where delta_valid is high
//   delta          signed two's-complement delta
//   scale          sensitivity selector
//   step_period    minimum cycles between steps minus one, sampled at reload
//   dir_q, clk_q   registered quadrature outputs derived from the phase
//   pending        accumulator nonzero
//   overflow       one-cycle pulse after an update that clamped
module quad_axis_channel
  import quad_emu_pkg::*;
#(
  parameter int DELTA_W = 9,
  parameter int ACC_W   = 12,
  parameter int PER_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      delta_valid,
  input  logic signed [DELTA_W-1:0] delta,
  input  scale_t                    scale,
  input  logic        [PER_W-1:0]   step_period,
  output logic                      dir_q,
  output logic                      clk_q,
  output logic                      pending,
  output logic                      overflow
);

  // Scaled delta width. Assumes DELTA_W+1 < ACC_W+1 so the x2 setting
  // cannot wrap.
  localparam int SW    = ACC_W + 1;
  // Headroom for acc + scaled - step before clamping.
  localparam int SUM_W = ACC_W + 3;

  localparam logic signed [SUM_W-1:0] LIM      = SUM_W'(sat_lim(ACC_W));
  localparam logic signed [SUM_W-1:0] NEG_LIM  = -LIM;
  localparam logic signed [SUM_W-1:0] STEP_ONE = SUM_W'(1);

  logic signed [ACC_W-1:0] acc;
  logic        [PER_W-1:0] timer;
  logic        [1:0]       phase;

  logic signed [SW-1:0]    d_ext;
  logic                    d_neg;
  logic signed [SW-1:0]    mag;
  logic signed [SW-1:0]    shifted;
  logic signed [SW-1:0]    scaled;
  logic                    issue;
  logic signed [SUM_W-1:0] step;
  logic signed [SUM_W-1:0] add_val;
  logic signed [SUM_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_next;
  logic                    clamp;
  logic        [PER_W-1:0] timer_next;
  logic        [1:0]       phase_next;

  always_comb begin
    // Scale the magnitude, then reapply the sign, so truncation is toward
    // zero for both polarities.
    d_ext = SW'(delta);
    d_neg = d_ext[SW-1];
    mag   = d_neg ? -d_ext : d_ext;
    case (scale)
      SCALE_QTR:  shifted = mag >>> 2;
      SCALE_HALF: shifted = mag >>> 1;
      SCALE_ONE:  shifted = mag;
      default:    shifted = mag <<< 1;
    endcase
    scaled = d_neg ? -shifted : shifted;

    issue = (timer == '0) && (acc != '0);

    // A step moves the accumulator one unit toward zero, using the sign
    // held before this update (a same-cycle delta may flip it afterwards).
    step = '0;
    if (issue) step = acc[ACC_W-1] ? -STEP_ONE : STEP_ONE;

    add_val = '0;
    if (delta_valid) add_val = SUM_W'(scaled);

    sum = SUM_W'(acc) + add_val - step;

    clamp    = 1'b0;
    acc_next = sum[ACC_W-1:0];
    if (sum > LIM) begin
      clamp    = 1'b1;
      acc_next = LIM[ACC_W-1:0];
    end else if (sum < NEG_LIM) begin
      clamp    = 1'b1;
      acc_next = NEG_LIM[ACC_W-1:0];
    end

    phase_next = phase;
    if (issue) phase_next = acc[ACC_W-1] ? phase - 2'd1 : phase + 2'd1;

    // Timer idles at zero so a fresh delta steps without a stale wait.
    timer_next = timer;
    if (issue)            timer_next = step_period;
    else if (timer != '0) timer_next = timer - PER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      timer    <= '0;
      phase    <= '0;
      dir_q    <= 1'b0;
      clk_q    <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      timer    <= '0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      acc      <= acc_next;
      timer    <= timer_next;
      phase    <= phase_next;
      // Gray encoding 00->01->11->10 for increasing phase.
      dir_q    <= phase_next[1];
      clk_q    <= phase_next[1] ^ phase_next[0];
      pending  <= (acc_next != '0);
      overflow <= clamp;
    end
  end

endmodule

// File: rtl/quad_axis_emu.sv
// N-axis quadrature encoder emulator. Each axis turns signed position
// deltas into a rate-limited dir/clk step stream that tracks position
// exactly. In passthru the outputs follow the real encoder inputs
// combinationally while the emulation engines are held cleared.
//
// Ports
//   clk, reset        core clock, synchronous active-high reset
//   delta_valid[i]    one-cycle strobe for axis i (always accepted, no ready)
//   delta             packed signed deltas, axis i at [i*DELTA_W +: DELTA_W]
//   scale             sensitivity for all axes (0:/4 1:/2 2:x1 3:x2)
//   step_period       minimum cycles between steps minus one
//   passthru          1 = outputs follow dir_in/clk_in
//   dir_in, clk_in    real encoder signals
//   dir_out, clk_out  emulated or passed-through quadrature
//   pending           accumulator nonzero per axis
//   overflow          one-cycle pulse per axis after a saturating update
module quad_axis_emu
  import quad_emu_pkg::*;
#(
  parameter int N_AXES  = 2,
  parameter int DELTA_W = 9,
  parameter int ACC_W   = 12,
  parameter int PER_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_AXES-1:0]           delta_valid,
  input  logic [N_AXES*DELTA_W-1:0]   delta,
  input  logic [1:0]                  scale,
  input  logic [PER_W-1:0]            step_period,
  input  logic                        passthru,
  input  logic [N_AXES-1:0]           dir_in,
  input  logic [N_AXES-1:0]           clk_in,
  output logic [N_AXES-1:0]           dir_out,
  output logic [N_AXES-1:0]           clk_out,
  output logic [N_AXES-1:0]           pending,
  output logic [N_AXES-1:0]           overflow
);

  logic [N_AXES-1:0] emu_dir;
  logic [N_AXES-1:0] emu_clk;

  for (genvar i = 0; i < N_AXES; i++) begin : g_axis
    quad_axis_channel #(
      .DELTA_W (DELTA_W),
      .ACC_W   (ACC_W),
      .PER_W   (PER_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .clear       (passthru),
      .delta_valid (delta_valid[i]),
      .delta       (delta[i*DELTA_W +: DELTA_W]),
      .scale       (scale_t'(scale)),
      .step_period (step_period),
      .dir_q       (emu_dir[i]),
      .clk_q       (emu_clk[i]),
      .pending     (pending[i]),
      .overflow    (overflow[i])
    );
  end

  assign dir_out = passthru ? dir_in : emu_dir;
  assign clk_out = passthru ? clk_in : emu_clk;

endmodule

// File: doc/quad_axis_emu.md
# quad_axis_emu

Parametrised N-axis quadrature encoder emulator that converts signed position deltas from mouse, analog-stick or digital-joystick front ends into rate-limited two-phase (dir/clk) step streams for the arcade core's trackball inputs. Each axis accumulates deltas and emits one quadrature step per `step_period + 1` cycles until the accumulator drains. This is exact position tracking, not speed emulation. A passthrough mode routes real SNAC encoder signals straight to the outputs.

## Interface
- `N_AXES`, 2, number of independent axes
- `DELTA_W`, 9, width of each signed two's-complement delta
- `ACC_W`, 12, signed accumulator width per axis
- `PER_W`, 16, width of the step-period counter

- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high reset
- `delta_valid`  in  N_AXES  per-axis one-cycle strobe; delta accepted on any cycle it is high
- `delta`  in  N_AXES*DELTA_W  packed signed deltas, axis i at `[i*DELTA_W +: DELTA_W]`; positive means increasing phase
- `scale`  in  2  sensitivity shared by all axes: 0 = |d|>>2, 1 = |d|>>1, 2 = ×1, 3 = ×2
- `step_period`  in  PER_W  minimum cycles between steps, minus one
- `passthru`  in  1  1 = outputs follow `dir_in`/`clk_in`
- `dir_in`, `clk_in`  in  N_AXES each  SNAC encoder signals
- `dir_out`, `clk_out`  out  N_AXES each  emulated or passed-through quadrature
- `pending`  out  N_AXES  accumulator nonzero
- `overflow`  out  N_AXES  one-cycle pulse when the accumulator saturated

## Operation
- **Scaling:** take the magnitude of the delta, shift it per `scale`, then reapply the sign. Truncation is toward zero, so −1 at scale 0 gives 0. Result is ACC_W+1 bits wide.
- **Accumulate:** each edge, compute `acc_next = sat(acc + scaled·delta_valid − step)`. `step` is ±1 when a step is issued this cycle and 0 otherwise.
  - Saturation is symmetric at ±(2^(ACC_W−1)−1).
  - When clamping occurs, `overflow` pulses on the following cycle.
- **Step engine:**
  - `timer` counts down and holds at 0.
  - When `timer == 0` and `acc != 0`: issue a step, `phase += sign(acc)` (2-bit wrap), and reload `timer` with `step_period`.
  - The step reduces the accumulator's magnitude by 1 in the same update.
- **Output encoding:** `dir_out = phase[1]`, `clk_out = phase[0] ^ phase[1]`. Increasing phase produces the Gray sequence 00→01→11→10.
- **Simultaneous step and delta:** both apply in the same update. An opposite-sign delta may flip the accumulator's sign; the next step then uses the new sign.
- **Passthru:**
  - Outputs mux combinationally to the inputs.
  - Accumulators and timers are held cleared and deltas are ignored.
  - `phase` is retained, so deasserting passthru produces no burst of steps.
- **Reset:** `acc`, `timer`, `phase`, `pending` and `overflow` are all 0, so `dir_out = clk_out = 0`. Reset applied mid-stream aborts pending steps immediately.

## Timing
- A delta strobed at edge n appears in `acc` (and raises `pending`) after edge n.
- The first step changes `phase`/outputs after edge n+1, i.e. two edges after the strobe edge, provided `timer` is 0.
- Step spacing is exactly `step_period + 1` cycles. With `step_period = 0` the engine steps every cycle.
- Idle `timer` reaches 0 and holds there, so a fresh delta after idle is never delayed by a stale period.
- `step_period` is sampled only at reload; changes take effect at the next step.
- Axes are fully independent, with no shared arbitration.
- All outputs are registered except in passthru, where outputs are combinational from the inputs.

## Structure
- Package `quad_emu_pkg`: a `scale_t` enum (`SCALE_QTR`, `SCALE_HALF`, `SCALE_ONE`, `SCALE_DBL`) and a saturation-limit constant function of ACC_W.
- Sub-module `quad_axis_channel` holds one axis (scale, accumulator, timer, phase). The top level instantiates it N_AXES times in a generate loop and implements the passthru mux.

## Test plan
- **Positive steps:** reset, `scale=2`, `step_period=0`, axis0 delta +3 → outputs go 00→01→11→10 on three consecutive cycles starting two edges after the strobe; `pending` falls with the third step.
- **Scaling to zero, then negative steps:** `scale=0`, delta −2 → scaled 0, no steps, `pending` stays 0. Delta −8 → 2 steps, outputs 00→10→11.
- **Rate limit:** `step_period=9`, delta +4 → 4 steps spaced exactly 10 cycles apart. Axis1 stays idle throughout.
- **Saturation:** ACC_W=12, `step_period=1000`, `scale=3`, five strobes of +255 (+510 each) → `acc` clamps at 2047 and `overflow` pulses once for exactly one cycle.
- **Cancellation:** with `acc=+5`, a delta of −5 lands on a step cycle → `acc = −1`. The next step decrements the phase.
- **Passthru and reset mid-stream:** assert `passthru` mid-stream → outputs equal `dir_in`/`clk_in` in the same cycle; deasserting shows no step burst. Pulse `reset` mid-stream → all outputs 0 on the next edge and `pending = 0`.
